// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings up three PLLs and releases the dependent clock-domain resets in a
// fixed, staggered order once every PLL has held lock for a stable period.
// It retries the PLL reset on lock timeout and latches FAULT after too many
// consecutive timeouts. Once running, a lock loss pulls every domain back
// into reset and restarts the whole sequence.
//
// Ports
//   clkin        in   1  24 MHz board clock
//   rst_n        in   1  asynchronous active-low reset
//   lock_core    in   1  asynchronous lock, core PLL
//   lock_hdmi    in   1  asynchronous lock, HDMI PLL
//   lock_audio   in   1  asynchronous lock, audio PLL
//   pll_rst      out  1  active-high reset to all three PLLs
//   core_rst_n   out  1  core domain reset (active low)
//   audio_rst_n  out  1  audio domain reset (active low)
//   hdmi_rst_n   out  1  HDMI domain reset (active low)
//   all_locked   out  1  system running
//   fault        out  1  retries exhausted, terminal until rst_n
//   retry_cnt    out  2  consecutive lock timeouts
//   loss_cnt     out  8  lock-loss events, saturating at 255
//   state        out  3  FSM state encoding
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 24,
  parameter int LOCK_TIMEOUT   = 240000,
  parameter int STABLE_CYCLES  = 2400,
  parameter int STAGGER_CYCLES = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       lock_core,
  input  logic       lock_hdmi,
  input  logic       lock_audio,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       audio_rst_n,
  output logic       hdmi_rst_n,
  output logic       all_locked,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  function automatic int max_of(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Counter must hold the largest terminal value of any timed state.
  localparam int MAX_P = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                max_of(STABLE_CYCLES, STAGGER_CYCLES));
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_REL_CORE  = 3'd3;
  localparam logic [2:0] ST_REL_AUDIO = 3'd4;
  localparam logic [2:0] ST_REL_HDMI  = 3'd5;
  localparam logic [2:0] ST_RUN       = 3'd6;
  localparam logic [2:0] ST_FAULT     = 3'd7;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  logic [2:0]       lock_meta_r;
  logic [2:0]       lock_sync_r;
  logic             all_sync_s;
  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       retry_r;
  logic [7:0]       loss_r;
  logic             pll_rst_r;
  logic             core_rst_n_r;
  logic             audio_rst_n_r;
  logic             hdmi_rst_n_r;
  logic             all_locked_r;
  logic             fault_r;

  logic [2:0]       next_state_s;
  logic [CNT_W-1:0] next_cnt_s;
  logic [1:0]       next_retry_s;
  logic [1:0]       retry_inc_s;
  logic [7:0]       next_loss_s;

  assign all_sync_s = &lock_sync_r;

  // Two-flop synchronizers for the three asynchronous lock inputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_r <= 3'b000;
      lock_sync_r <= 3'b000;
    end else begin
      lock_meta_r <= {lock_hdmi, lock_audio, lock_core};
      lock_sync_r <= lock_meta_r;
    end
  end

  // Next-state, counter and event-counter logic.
  always_comb begin
    next_state_s = state_r;
    next_retry_s = retry_r;
    next_loss_s  = loss_r;
    retry_inc_s  = retry_r + 2'd1;
    case (state_r)
      ST_PLL_RST: begin
        if (cnt_r == PLL_RST_LAST) begin
          next_state_s = ST_WAIT_LOCK;
        end else begin
          next_state_s = ST_PLL_RST;
        end
      end
      ST_WAIT_LOCK: begin
        if (all_sync_s) begin
          next_state_s = ST_STABLE;
        end else if (cnt_r == LOCK_LAST) begin
          next_retry_s = retry_inc_s;
          if (retry_inc_s == RETRY_LIMIT) begin
            next_state_s = ST_FAULT;
          end else begin
            next_state_s = ST_PLL_RST;
          end
        end else begin
          next_state_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        // Any drop restarts the lock wait; retries are not charged for it.
        if (!all_sync_s) begin
          next_state_s = ST_WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          next_state_s = ST_REL_CORE;
          next_retry_s = 2'd0;
        end else begin
          next_state_s = ST_STABLE;
        end
      end
      // In the release and run states a lock drop wins over stagger expiry.
      ST_REL_CORE: begin
        if (!all_sync_s) begin
          next_state_s = ST_PLL_RST;
          next_loss_s  = sat_inc8(loss_r);
        end else if (cnt_r == STAGGER_LAST) begin
          next_state_s = ST_REL_AUDIO;
        end else begin
          next_state_s = ST_REL_CORE;
        end
      end
      ST_REL_AUDIO: begin
        if (!all_sync_s) begin
          next_state_s = ST_PLL_RST;
          next_loss_s  = sat_inc8(loss_r);
        end else if (cnt_r == STAGGER_LAST) begin
          next_state_s = ST_REL_HDMI;
        end else begin
          next_state_s = ST_REL_AUDIO;
        end
      end
      ST_REL_HDMI: begin
        if (!all_sync_s) begin
          next_state_s = ST_PLL_RST;
          next_loss_s  = sat_inc8(loss_r);
        end else if (cnt_r == STAGGER_LAST) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_REL_HDMI;
        end
      end
      ST_RUN: begin
        if (!all_sync_s) begin
          next_state_s = ST_PLL_RST;
          next_loss_s  = sat_inc8(loss_r);
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        next_state_s = ST_FAULT;
      end
      default: begin
        next_state_s = ST_PLL_RST;
      end
    endcase

    // Counter restarts on every state change and is frozen in untimed states.
    if (next_state_s != state_r) begin
      next_cnt_s = CNT_ZERO;
    end else if ((state_r == ST_RUN) || (state_r == ST_FAULT)) begin
      next_cnt_s = cnt_r;
    end else begin
      next_cnt_s = cnt_r + CNT_ONE;
    end
  end

  // State, counter and event-counter registers.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_PLL_RST;
      cnt_r   <= CNT_ZERO;
      retry_r <= 2'd0;
      loss_r  <= 8'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      retry_r <= next_retry_s;
      loss_r  <= next_loss_s;
    end
  end

  // Output registers decoded from the next state so they change with it.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_r     <= 1'b1;
      core_rst_n_r  <= 1'b0;
      audio_rst_n_r <= 1'b0;
      hdmi_rst_n_r  <= 1'b0;
      all_locked_r  <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      pll_rst_r     <= (next_state_s == ST_PLL_RST) || (next_state_s == ST_FAULT);
      core_rst_n_r  <= (next_state_s == ST_REL_CORE) || (next_state_s == ST_REL_AUDIO) ||
                       (next_state_s == ST_REL_HDMI) || (next_state_s == ST_RUN);
      audio_rst_n_r <= (next_state_s == ST_REL_AUDIO) || (next_state_s == ST_REL_HDMI) ||
                       (next_state_s == ST_RUN);
      hdmi_rst_n_r  <= (next_state_s == ST_REL_HDMI) || (next_state_s == ST_RUN);
      all_locked_r  <= (next_state_s == ST_RUN);
      fault_r       <= (next_state_s == ST_FAULT);
    end
  end

  assign pll_rst     = pll_rst_r;
  assign core_rst_n  = core_rst_n_r;
  assign audio_rst_n = audio_rst_n_r;
  assign hdmi_rst_n  = hdmi_rst_n_r;
  assign all_locked  = all_locked_r;
  assign fault       = fault_r;
  assign retry_cnt   = retry_r;
  assign loss_cnt    = loss_r;
  assign state       = state_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with shortened timing parameters.
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT response is sampled (1 time unit after the rising edge).
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_TO  = 50;
  localparam int P_ST  = 10;
  localparam int P_SG  = 3;
  localparam int P_MR  = 3;

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       lock_core;
  logic       lock_hdmi;
  logic       lock_audio;
  logic       pll_rst;
  logic       core_rst_n;
  logic       audio_rst_n;
  logic       hdmi_rst_n;
  logic       all_locked;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  always #5 clkin = ~clkin;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_ST),
    .STAGGER_CYCLES(P_SG),
    .MAX_RETRIES   (P_MR)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .lock_core  (lock_core),
    .lock_hdmi  (lock_hdmi),
    .lock_audio (lock_audio),
    .pll_rst    (pll_rst),
    .core_rst_n (core_rst_n),
    .audio_rst_n(audio_rst_n),
    .hdmi_rst_n (hdmi_rst_n),
    .all_locked (all_locked),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .state      (state)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic rel_seen = 1'b0;
  logic run_seen = 1'b0;

  // Background observers on the falling edge: any domain release, any RUN.
  always @(negedge clkin) begin
    if (core_rst_n || audio_rst_n || hdmi_rst_n) rel_seen = 1'b1;
    if ((state == 3'd6) || all_locked) run_seen = 1'b1;
  end

  function automatic logic [31:0] mk(input logic p, input logic c, input logic a,
                                     input logic h, input logic al, input logic f,
                                     input logic [1:0] r, input logic [7:0] l,
                                     input logic [2:0] s);
    return {13'd0, p, c, a, h, al, f, r, l, s};
  endfunction

  function automatic logic [31:0] sel(input int which);
    case (which)
      0: return 32'(pll_rst);
      1: return 32'(core_rst_n);
      2: return 32'(audio_rst_n);
      3: return 32'(hdmi_rst_n);
      4: return 32'(all_locked);
      5: return 32'(fault);
      6: return 32'(retry_cnt);
      7: return 32'(loss_cnt);
      8: return 32'(state);
      default: return mk(pll_rst, core_rst_n, audio_rst_n, hdmi_rst_n, all_locked,
                         fault, retry_cnt, loss_cnt, state);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Ticks until the selected output equals val or the budget runs out.
  task automatic wait_for(input int which, input logic [31:0] val, input int budget,
                          output int n);
    n = 0;
    while ((sel(which) !== val) && (n < budget)) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen_wait;
    logic [31:0] rst_snap;
    rst_snap = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0);

    // Reset values.
    rst_n = 1'b0; lock_core = 1'b0; lock_hdmi = 1'b0; lock_audio = 1'b0;
    tick(3);
    expect_val("reset_snapshot", rst_snap); check(sel(9));

    // Normal bring-up.
    rst_n = 1'b1;
    expect_val("pll_rst_high_cycles", 32'(P_RST));
    wait_for(0, 32'd0, 20, n); check(32'(n));
    expect_val("wait_lock_after_pll_rst", 32'd1); check(sel(8));
    tick(5);
    lock_core = 1'b1; lock_hdmi = 1'b1; lock_audio = 1'b1;
    tick(1);  // first edge that samples the raised locks
    expect_val("core_release_delay", 32'(2 + P_ST));
    wait_for(1, 32'd1, 40, n); check(32'(n));
    expect_val("audio_held_at_core", 32'd0); check(sel(2));
    expect_val("audio_after_core", 32'(P_SG));
    wait_for(2, 32'd1, 20, n); check(32'(n));
    expect_val("hdmi_after_audio", 32'(P_SG));
    wait_for(3, 32'd1, 20, n); check(32'(n));
    expect_val("run_after_hdmi", 32'(P_SG));
    wait_for(4, 32'd1, 20, n); check(32'(n));
    expect_val("run_snapshot", mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 3'd6));
    check(sel(9));

    // Lock loss in RUN.
    lock_core = 1'b0;
    tick(2);
    expect_val("run_during_sync", 32'd6); check(sel(8));
    tick(1);
    expect_val("loss_snapshot", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 3'd0));
    check(sel(9));
    lock_core = 1'b1;
    wait_for(4, 32'd1, 100, n);
    expect_val("rerun_snapshot", mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1, 3'd6));
    check(sel(9));

    // Asynchronous reset in mid-sequence.
    rst_n = 1'b0;
    #1;
    expect_val("async_reset_in_run", rst_snap); check(sel(9));

    // One timeout, then a stability abort.
    lock_core = 1'b0; lock_hdmi = 1'b0; lock_audio = 1'b0;
    tick(2);
    rst_n = 1'b1;
    expect_val("first_timeout_cycles", 32'(P_RST + P_TO));
    wait_for(6, 32'd1, 100, n); check(32'(n));
    expect_val("after_timeout_snapshot", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 3'd0));
    check(sel(9));
    lock_core = 1'b1; lock_hdmi = 1'b1; lock_audio = 1'b1;
    expect_val("reach_stable", 32'd2);
    wait_for(8, 32'd2, 40, n); check(sel(8));
    tick(3);
    rel_seen = 1'b0;
    seen_wait = 1'b0;
    lock_hdmi = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (state == 3'd1) seen_wait = 1'b1;
      if (i == 2) lock_hdmi = 1'b1;
    end
    expect_val("stable_abort_to_wait", 32'd1); check(32'(seen_wait));
    expect_val("stable_abort_no_release", 32'd0); check(32'(rel_seen));
    expect_val("stable_abort_retry_kept", 32'd1); check(sel(6));
    expect_val("restable_state", 32'd2); check(sel(8));
    wait_for(4, 32'd1, 60, n);
    expect_val("retry_cleared_in_run", 32'd0); check(sel(6));
    expect_val("run_after_abort", 32'd6); check(sel(8));

    // Repeated timeouts into FAULT.
    rst_n = 1'b0;
    lock_audio = 1'b0;
    tick(1);
    rel_seen = 1'b0;
    rst_n = 1'b1;
    expect_val("retry1_cycles", 32'(P_RST + P_TO));
    wait_for(6, 32'd1, 100, n); check(32'(n));
    expect_val("retry1_state", 32'd0); check(sel(8));
    expect_val("retry2_cycles", 32'(P_RST + P_TO));
    wait_for(6, 32'd2, 100, n); check(32'(n));
    expect_val("retry2_state", 32'd0); check(sel(8));
    expect_val("fault_cycles", 32'(P_RST + P_TO));
    wait_for(5, 32'd1, 100, n); check(32'(n));
    expect_val("fault_snapshot", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0, 3'd7));
    check(sel(9));
    lock_audio = 1'b1;
    tick(10);
    expect_val("fault_terminal", 32'd7); check(sel(8));
    expect_val("fault_no_release", 32'd0); check(32'(rel_seen));

    // Asynchronous reset while in FAULT, checked before any clock edge.
    rst_n = 1'b0;
    #1;
    expect_val("async_fault_clear", 32'd0); check(sel(5));
    expect_val("async_retry_clear", 32'd0); check(sel(6));
    expect_val("async_state_clear", 32'd0); check(sel(8));

    // Lock drop on the final cycle of REL_HDMI must beat the stagger expiry.
    tick(1);
    rst_n = 1'b1;
    run_seen = 1'b0;
    expect_val("hdmi_released", 32'd1);
    wait_for(3, 32'd1, 60, n); check(sel(3));
    lock_core = 1'b0;
    tick(3);
    expect_val("collision_snapshot", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 3'd0));
    check(sel(9));
    tick(7);
    expect_val("collision_never_run", 32'd0); check(32'(run_seen));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
